// File: rtl/cpu24_pkg.sv
// Purpose: shared sizes and requester indices for the 24-bit CPU register-file slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: DATA_W, ADDR_W, NUM_REGS, and REQ_ALU/REQ_MUL, the index of each writeback source in grant vectors.
package cpu24_pkg;

    localparam int DATA_W   = 24;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    localparam int REQ_ALU  = 0;
    localparam int REQ_MUL  = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Purpose: 2-way round-robin arbiter with a last-grant pointer.
// Latency: grant is combinational from req; the pointer updates at the clock edge.
// Backpressure: a requester that is not granted simply sees gnt low and keeps requesting.
// Ports: clk, rst_n (async active-low), req[1:0] request vector, gnt[1:0] one-hot grant (or zero).
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Index of the requester granted most recently. It resets to 1, so requester 0 wins the first tie.
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Purpose: round-robin share of the register-file write port between ALU and MUL, plus a destination scoreboard.
// Latency: accept at edge N -> RegWrite/RD/WriteData valid after edge N -> register file captures at edge N+1.
// Backpressure: ReqNReady is high only while requester N holds the grant; ResReady is low while the target is busy.
// Ports: Clock, Reset_n (async active-low); Req0*/Req1* valid/ready writeback requests; Res* issue-time reservation;
//        RS/RT are hazard queries answered on HazardRS/HazardRT; RegWrite/RD/WriteData form the registered write port;
//        Busy is the scoreboard; ErrUnreserved is a sticky error flag; Fwd* are the optional forwarding outputs.
// Config: define REGFILE_WRITE_ARBITER_BYPASS_EN to forward the committing write to RS/RT and mask those hazards.
module regfile_write_arbiter
    import cpu24_pkg::*;
#(
    parameter int DATA_W   = cpu24_pkg::DATA_W,
    parameter int ADDR_W   = cpu24_pkg::ADDR_W,
    parameter int NUM_REGS = cpu24_pkg::NUM_REGS
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Req0Valid,
    input  logic [ADDR_W-1:0]   Req0Rd,
    input  logic [DATA_W-1:0]   Req0Data,
    output logic                Req0Ready,
    input  logic                Req1Valid,
    input  logic [ADDR_W-1:0]   Req1Rd,
    input  logic [DATA_W-1:0]   Req1Data,
    output logic                Req1Ready,
    input  logic                ResValid,
    input  logic [ADDR_W-1:0]   ResRd,
    output logic                ResReady,
    input  logic [ADDR_W-1:0]   RS,
    input  logic [ADDR_W-1:0]   RT,
    output logic                HazardRS,
    output logic                HazardRT,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   RD,
    output logic [DATA_W-1:0]   WriteData,
    output logic [NUM_REGS-1:0] Busy,
    output logic                ErrUnreserved,
    output logic                FwdRSValid,
    output logic                FwdRTValid,
    output logic [DATA_W-1:0]   FwdRSData,
    output logic [DATA_W-1:0]   FwdRTData
);

    logic [1:0]          gnt;
    logic                xfer;
    logic [ADDR_W-1:0]   sel_rd;
    logic [DATA_W-1:0]   sel_dat;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                res_fire;

    rr_arbiter2 u_arb (
        .clk   (Clock),
        .rst_n (Reset_n),
        .req   ({Req1Valid, Req0Valid}),
        .gnt   (gnt)
    );

    assign Req0Ready = gnt[REQ_ALU];
    assign Req1Ready = gnt[REQ_MUL];

    // The grant is only ever given to a valid requester, so any grant is a transfer.
    assign xfer    = |gnt;
    assign sel_rd  = gnt[REQ_MUL] ? Req1Rd   : Req0Rd;
    assign sel_dat = gnt[REQ_MUL] ? Req1Data : Req0Data;

    // Commit register. RD and WriteData hold their last value when nothing is accepted.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            RegWrite  <= 1'b0;
            RD        <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= xfer;
            if (xfer) begin
                RD        <= sel_rd;
                WriteData <= sel_dat;
            end
        end
    end

    assign ResReady = ~busy_q[ResRd];
    assign res_fire = ResValid & ResReady;

    // The clear is applied before the set, so a reservation landing on the
    // edge where the same register commits leaves it busy.
    always_comb begin
        busy_nxt = busy_q;
        if (RegWrite) begin
            busy_nxt[RD] = 1'b0;
        end
        if (res_fire) begin
            busy_nxt[ResRd] = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_q        <= '0;
            ErrUnreserved <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            if (RegWrite && !busy_q[RD]) begin
                ErrUnreserved <= 1'b1;
            end
        end
    end

    assign Busy = busy_q;

`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
    // The write being captured this cycle is visible to decode, so a match
    // against it is served from the write port and is not a hazard.
    assign FwdRSValid = RegWrite && (RD == RS);
    assign FwdRTValid = RegWrite && (RD == RT);
    assign FwdRSData  = WriteData;
    assign FwdRTData  = WriteData;
    assign HazardRS   = busy_q[RS] & ~FwdRSValid;
    assign HazardRT   = busy_q[RT] & ~FwdRTValid;
`else
    assign FwdRSValid = 1'b0;
    assign FwdRTValid = 1'b0;
    assign FwdRSData  = '0;
    assign FwdRTData  = '0;
    assign HazardRS   = busy_q[RS];
    assign HazardRT   = busy_q[RT];
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose: directed table-driven bench for regfile_write_arbiter plus hand-written multi-cycle sequences.
// Latency: inputs are driven on the falling edge and outputs are sampled 2 time units later.
// Backpressure: requesters hold Valid/Rd/Data until the expected Ready, as encoded in the vectors.
module tb_regfile_write_arbiter;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Req0Valid, Req1Valid, ResValid;
    logic [3:0]  Req0Rd, Req1Rd, ResRd, RS, RT;
    logic [23:0] Req0Data, Req1Data;
    logic        Req0Ready, Req1Ready, ResReady, HazardRS, HazardRT;
    logic        RegWrite, ErrUnreserved, FwdRSValid, FwdRTValid;
    logic [3:0]  RD;
    logic [23:0] WriteData, FwdRSData, FwdRTData;
    logic [15:0] Busy;

    int n_chk = 0;
    int n_err = 0;

    regfile_write_arbiter dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Req0Valid(Req0Valid), .Req0Rd(Req0Rd), .Req0Data(Req0Data), .Req0Ready(Req0Ready),
        .Req1Valid(Req1Valid), .Req1Rd(Req1Rd), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
        .ResValid(ResValid), .ResRd(ResRd), .ResReady(ResReady),
        .RS(RS), .RT(RT), .HazardRS(HazardRS), .HazardRT(HazardRT),
        .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
        .Busy(Busy), .ErrUnreserved(ErrUnreserved),
        .FwdRSValid(FwdRSValid), .FwdRTValid(FwdRTValid),
        .FwdRSData(FwdRSData), .FwdRTData(FwdRTData)
    );

    always #5 Clock = ~Clock;

    // Flag order in ef: Req0Ready Req1Ready ResReady HazardRS HazardRT RegWrite.
    typedef struct {
        logic        r0v;
        logic [3:0]  r0rd;
        logic [23:0] r0d;
        logic        r1v;
        logic [3:0]  r1rd;
        logic [23:0] r1d;
        logic        rv;
        logic [3:0]  rrd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [5:0]  ef;
        logic [3:0]  erd;
        logic [23:0] ewd;
        logic [15:0] ebusy;
        logic        eerr;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(
        input logic r0v, input logic [3:0] r0rd, input logic [23:0] r0d,
        input logic r1v, input logic [3:0] r1rd, input logic [23:0] r1d,
        input logic rv, input logic [3:0] rrd, input logic [3:0] rs, input logic [3:0] rt,
        input logic [5:0] ef, input logic [3:0] erd, input logic [23:0] ewd,
        input logic [15:0] ebusy, input logic eerr);
        vec_t v;
        v.r0v = r0v; v.r0rd = r0rd; v.r0d = r0d;
        v.r1v = r1v; v.r1rd = r1rd; v.r1d = r1d;
        v.rv = rv; v.rrd = rrd; v.rs = rs; v.rt = rt;
        v.ef = ef; v.erd = erd; v.ewd = ewd; v.ebusy = ebusy; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        Req0Valid = 1'b0; Req0Rd = 4'd0; Req0Data = 24'h0;
        Req1Valid = 1'b0; Req1Rd = 4'd0; Req1Data = 24'h0;
        ResValid  = 1'b0; ResRd  = 4'd0; RS = 4'd0; RT = 4'd0;
    endtask

    logic exp_fwd;

    initial begin
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
        exp_fwd = 1'b1;
`else
        exp_fwd = 1'b0;
`endif
        //            r0v  r0rd  r0d           r1v  r1rd  r1d           rv   rrd   rs    rt    flags      erd   ewd           busy      err
        tbl[0]  = mk(1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 4'd0, 4'd0, 6'b001000, 4'd0, 24'h0,      16'h0000, 1'b0);
        tbl[1]  = mk(1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 24'h0,      1'b1, 4'd5, 4'd5, 4'd0, 6'b001000, 4'd0, 24'h0,      16'h0000, 1'b0);
        tbl[2]  = mk(1'b1, 4'd5, 24'hABCDEF, 1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 4'd5, 4'd0, 6'b101100, 4'd0, 24'h0,      16'h0020, 1'b0);
        tbl[3]  = mk(1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 4'd0, 4'd0, 6'b001001, 4'd5, 24'hABCDEF, 16'h0020, 1'b0);
        tbl[4]  = mk(1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 4'd5, 4'd0, 6'b001000, 4'd5, 24'hABCDEF, 16'h0000, 1'b0);
        tbl[5]  = mk(1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 24'h0,      1'b1, 4'd1, 4'd0, 4'd0, 6'b001000, 4'd5, 24'hABCDEF, 16'h0000, 1'b0);
        tbl[6]  = mk(1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 24'h0,      1'b1, 4'd2, 4'd0, 4'd0, 6'b001000, 4'd5, 24'hABCDEF, 16'h0002, 1'b0);
        tbl[7]  = mk(1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 24'h0,      1'b1, 4'd3, 4'd0, 4'd0, 6'b001000, 4'd5, 24'hABCDEF, 16'h0006, 1'b0);
        tbl[8]  = mk(1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 24'h0,      1'b1, 4'd4, 4'd0, 4'd0, 6'b001000, 4'd5, 24'hABCDEF, 16'h000E, 1'b0);
        tbl[9]  = mk(1'b1, 4'd1, 24'h111111, 1'b1, 4'd2, 24'h222222, 1'b1, 4'd6, 4'd0, 4'd0, 6'b011000, 4'd5, 24'hABCDEF, 16'h001E, 1'b0);
        tbl[10] = mk(1'b1, 4'd1, 24'h111111, 1'b1, 4'd4, 24'h444444, 1'b0, 4'd0, 4'd0, 4'd0, 6'b101001, 4'd2, 24'h222222, 16'h005E, 1'b0);
        tbl[11] = mk(1'b1, 4'd3, 24'h333333, 1'b1, 4'd4, 24'h444444, 1'b0, 4'd0, 4'd0, 4'd0, 6'b011001, 4'd1, 24'h111111, 16'h005A, 1'b0);
        tbl[12] = mk(1'b1, 4'd3, 24'h333333, 1'b1, 4'd6, 24'h666666, 1'b0, 4'd0, 4'd0, 4'd0, 6'b101001, 4'd4, 24'h444444, 16'h0058, 1'b0);
        tbl[13] = mk(1'b0, 4'd0, 24'h0,      1'b1, 4'd6, 24'h666666, 1'b0, 4'd0, 4'd0, 4'd6, 6'b011011, 4'd3, 24'h333333, 16'h0048, 1'b0);
        tbl[14] = mk(1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 4'd0, 4'd0, 6'b001001, 4'd6, 24'h666666, 16'h0040, 1'b0);
        tbl[15] = mk(1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 4'd0, 4'd0, 6'b001000, 4'd6, 24'h666666, 16'h0000, 1'b0);

        idle();
        Reset_n = 1'b0;
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge Clock);
            Req0Valid = tbl[i].r0v; Req0Rd = tbl[i].r0rd; Req0Data = tbl[i].r0d;
            Req1Valid = tbl[i].r1v; Req1Rd = tbl[i].r1rd; Req1Data = tbl[i].r1d;
            ResValid  = tbl[i].rv;  ResRd  = tbl[i].rrd;
            RS = tbl[i].rs; RT = tbl[i].rt;
            #2;
            chk($sformatf("row%0d Req0Ready", i), {31'd0, Req0Ready}, {31'd0, tbl[i].ef[5]});
            chk($sformatf("row%0d Req1Ready", i), {31'd0, Req1Ready}, {31'd0, tbl[i].ef[4]});
            chk($sformatf("row%0d ResReady", i),  {31'd0, ResReady},  {31'd0, tbl[i].ef[3]});
            chk($sformatf("row%0d HazardRS", i),  {31'd0, HazardRS},  {31'd0, tbl[i].ef[2]});
            chk($sformatf("row%0d HazardRT", i),  {31'd0, HazardRT},  {31'd0, tbl[i].ef[1]});
            chk($sformatf("row%0d RegWrite", i),  {31'd0, RegWrite},  {31'd0, tbl[i].ef[0]});
            chk($sformatf("row%0d RD", i),        {28'd0, RD},        {28'd0, tbl[i].erd});
            chk($sformatf("row%0d WriteData", i), {8'd0, WriteData},  {8'd0, tbl[i].ewd});
            chk($sformatf("row%0d Busy", i),      {16'd0, Busy},      {16'd0, tbl[i].ebusy});
            chk($sformatf("row%0d ErrUnres", i),  {31'd0, ErrUnreserved}, {31'd0, tbl[i].eerr});
        end

        // Unreserved write to R9 by MUL, with a reservation of R9 on the commit edge (set beats clear).
        @(negedge Clock);
        idle();
        Req1Valid = 1'b1; Req1Rd = 4'd9; Req1Data = 24'h000099;
        #2;
        chk("r9 Req1Ready", {31'd0, Req1Ready}, 32'd1);
        chk("r9 Req0Ready", {31'd0, Req0Ready}, 32'd0);
        @(negedge Clock);
        idle();
        ResValid = 1'b1; ResRd = 4'd9; RS = 4'd9;
        #2;
        chk("r9 commit RegWrite", {31'd0, RegWrite}, 32'd1);
        chk("r9 commit RD", {28'd0, RD}, 32'd9);
        chk("r9 commit WriteData", {8'd0, WriteData}, 32'h000099);
        chk("r9 ResReady on commit", {31'd0, ResReady}, 32'd1);
        chk("r9 FwdRSValid", {31'd0, FwdRSValid}, {31'd0, exp_fwd});
        @(negedge Clock);
        idle();
        RS = 4'd9;
        #2;
        chk("r9 set-wins Busy", {16'd0, Busy}, 32'h0200);
        chk("r9 ErrUnreserved", {31'd0, ErrUnreserved}, 32'd1);
        chk("r9 RegWrite drops", {31'd0, RegWrite}, 32'd0);
        chk("r9 HazardRS", {31'd0, HazardRS}, 32'd1);
        @(negedge Clock);
        idle();
        ResValid = 1'b1; ResRd = 4'd9;
        #2;
        chk("busy reserve ResReady", {31'd0, ResReady}, 32'd0);
        @(negedge Clock);
        idle();
        #2;
        chk("busy reserve no change", {16'd0, Busy}, 32'h0200);
        chk("err sticky", {31'd0, ErrUnreserved}, 32'd1);

        // Forwarding: reserve R2, ALU writes 0x42, query R2 during the commit cycle.
        @(negedge Clock);
        idle();
        ResValid = 1'b1; ResRd = 4'd2;
        @(negedge Clock);
        idle();
        Req0Valid = 1'b1; Req0Rd = 4'd2; Req0Data = 24'h000042;
        #2;
        chk("fwd Req0Ready", {31'd0, Req0Ready}, 32'd1);
        @(negedge Clock);
        idle();
        RS = 4'd2; RT = 4'd2;
        #2;
        chk("fwd FwdRSValid", {31'd0, FwdRSValid}, {31'd0, exp_fwd});
        chk("fwd FwdRTValid", {31'd0, FwdRTValid}, {31'd0, exp_fwd});
        chk("fwd FwdRSData", {8'd0, FwdRSData}, exp_fwd ? 32'h000042 : 32'h0);
        chk("fwd HazardRS", {31'd0, HazardRS}, {31'd0, ~exp_fwd});
        chk("fwd HazardRT", {31'd0, HazardRT}, {31'd0, ~exp_fwd});

        // Reset in the middle of a commit: the write port drops at once, without waiting for a clock edge.
        @(negedge Clock);
        idle();
        Req0Valid = 1'b1; Req0Rd = 4'd7; Req0Data = 24'h777777;
        #2;
        chk("midrst Req0Ready", {31'd0, Req0Ready}, 32'd1);
        @(posedge Clock);
        #1;
        chk("midrst RegWrite before", {31'd0, RegWrite}, 32'd1);
        idle();
        Reset_n = 1'b0;
        #1;
        chk("midrst RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("midrst Busy", {16'd0, Busy}, 32'h0);
        chk("midrst ErrUnreserved", {31'd0, ErrUnreserved}, 32'd0);
        chk("midrst RD", {28'd0, RD}, 32'd0);
        chk("midrst WriteData", {8'd0, WriteData}, 32'h0);
        @(negedge Clock);
        Reset_n = 1'b1;
        // The pointer is back at 1, so requester 0 wins the first tie.
        Req0Valid = 1'b1; Req0Rd = 4'd1; Req0Data = 24'h1;
        Req1Valid = 1'b1; Req1Rd = 4'd2; Req1Data = 24'h2;
        #2;
        chk("postrst tie Req0Ready", {31'd0, Req0Ready}, 32'd1);
        chk("postrst tie Req1Ready", {31'd0, Req1Ready}, 32'd0);
        chk("postrst ResReady", {31'd0, ResReady}, 32'd1);
        @(negedge Clock);
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
